jit_cmd_issuer: RTL and testbench
=================================

JIT_CMD_ISSUER -- requirements
Module: jit_cmd_issuer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: cycles to wait in WAIT for a ring return before reporting timeout; legal range 1..65535.
REQ-002 ACLK  input  1  single clock; all state updates on its rising edge.
REQ-003 ARESET  input  1  asynchronous, active-high reset.
REQ-004 sH_tready  output  1  host command channel ready.
REQ-005 sH_tvalid  input  1  host command valid.
REQ-006 sH_tdata  input  12  host command: [3:0] confA, [7:4] confB, [11:8] target key.
REQ-007 mR_tready  input  1  ring egress ready.
REQ-008 mR_tvalid  output  1  ring egress valid.
REQ-009 mR_tdata  output  32  ring egress command word.
REQ-010 sR_tready  output  1  ring ingress ready.
REQ-011 sR_tvalid  input  1  ring ingress valid.
REQ-012 sR_tdata  input  32  ring ingress word (acknowledge or unclaimed echo).
REQ-013 mH_tready  input  1  host response ready.
REQ-014 mH_tvalid  output  1  host response valid.
REQ-015 mH_tdata  output  32  response: [1:0] status, [11:8] key, [31:16] latency; other bits 0.
REQ-016 STRAY  output  8  count of ring words received outside WAIT, saturating at 255.

Function
REQ-017 FSM SHALL be one-hot with states IDLE, SEND, WAIT, RESP; exactly one state bit set at all times.
REQ-018 IDLE: sH_tready=1; on sH_tvalid SHALL capture sH_tdata and go to SEND next cycle.
REQ-019 SEND: mR_tvalid=1, mR_tdata={20'b0, key, confB, confA} held stable; on mR_tready go to WAIT and clear latency counter to 0.
REQ-020 WAIT: sR_tready=1; latency counter SHALL increment each cycle, saturating at 16'hFFFF.
REQ-021 WAIT, sR_tvalid with sR_tdata == {28'b0, key}: status ACK (2'b00); go to RESP.
REQ-022 WAIT, sR_tvalid with any other value: status NACK (2'b01); go to RESP; ACK comparison takes precedence (key 0, confA=confB=0).
REQ-023 WAIT, no sR_tvalid and latency counter == TIMEOUT_CYCLES-1: status TIMEOUT (2'b10); go to RESP.
REQ-024 Simultaneous sR_tvalid and timeout in same cycle: ring word SHALL win (ACK/NACK, not TIMEOUT).
REQ-025 Latency reported SHALL equal number of WAIT cycles before the terminating cycle (return in first WAIT cycle reports 0).
REQ-026 RESP: mH_tvalid=1, mH_tdata stable; on mH_tready return to IDLE.
REQ-027 sR_tready SHALL be 1 in IDLE, WAIT, RESP and 0 in SEND; words accepted in IDLE/RESP SHALL be discarded and increment STRAY.
REQ-028 sH_tready SHALL be 0 outside IDLE; only one command outstanding at a time.
REQ-029 Valids SHALL be registered-state decodes only (no combinational path from any input to any valid/ready).

Reset
REQ-030 ARESET asserted SHALL asynchronously force state IDLE, captured command 0, latency 0, status 0, STRAY 0.
REQ-031 Reset values: sH_tready=1, mR_tvalid=0, mR_tdata=0, sR_tready=1, mH_tvalid=0, mH_tdata=0, STRAY=0.
REQ-032 Reset mid-transaction (any state) SHALL abandon it with no response; a late ring return then counts as STRAY.

Structure
REQ-033 Shared package SHALL hold state indices (IDLE,SEND,WAIT,RESP), status codes (ACK,NACK,TIMEOUT), and command-word field positions (confA [3:0], confB [7:4], key [11:8]) shared with the ring-side command receiver.
REQ-034 One sub-module, jit_cmd_timer: 16-bit saturating latency counter with clear and timeout compare; everything else flat.

Verification
REQ-035 Host 12'h321, mR_tready=1, ring returns 32'h3 two cycles after egress -> mR_tdata 32'h321, response status ACK, key 3, latency 1.
REQ-036 Host 12'h5A7, ring returns 32'h5A7 unchanged -> status NACK, key 5.
REQ-037 TIMEOUT_CYCLES=8, no ring return -> response TIMEOUT exactly 8 cycles after WAIT entry, latency 7.
REQ-038 sR_tvalid in cycle where counter hits TIMEOUT_CYCLES-1 with 32'h3 for key 3 -> ACK, not TIMEOUT.
REQ-039 Backpressure: mR_tready low 5 cycles, mH_tready low 3 cycles -> data stable, no duplicates; 300 ring words in IDLE -> STRAY=255.
REQ-040 ARESET pulsed in WAIT, then return 32'h3 -> no response, STRAY=1, sH_tready=1.

Source files
------------

// File: rtl/jit_cmd_pkg.sv
// jit_cmd_pkg: state encoding, status codes and command-word field layout
// shared by the issuer and the ring-side command receiver.
package jit_cmd_pkg;
    localparam int I_IDLE = 0, I_SEND = 1, I_WAIT = 2, I_RESP = 3;
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        SEND = 4'b0010,
        WAIT = 4'b0100,
        RESP = 4'b1000
    } state_e;
    typedef enum logic [1:0] {
        ST_ACK     = 2'b00,
        ST_NACK    = 2'b01,
        ST_TIMEOUT = 2'b10
    } status_e;
    localparam int CMD_W = 12, FLD_W = 4;
    localparam int CONFA_LSB = 0, CONFB_LSB = 4, KEY_LSB = 8;
    function automatic logic [FLD_W-1:0] cmd_key(input logic [CMD_W-1:0] c);
        return c[KEY_LSB +: FLD_W];
    endfunction
endpackage

// File: rtl/jit_cmd_timer.sv
// jit_cmd_timer: 16-bit saturating latency counter with clear and timeout compare.
module jit_cmd_timer
    import jit_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [15:0] cnt_o,
    output logic        hit_o
);
    logic [15:0] cnt_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
    assign cnt_o = cnt_q;
    assign hit_o = cnt_q == 16'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/jit_cmd_issuer.sv
// jit_cmd_issuer: issues one host command onto the ring, waits for its return
// (ack, nack or timeout) and reports status, key and latency back to the host.
module jit_cmd_issuer
    import jit_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             ACLK,
    input  logic             ARESET,
    output logic             sH_tready,
    input  logic             sH_tvalid,
    input  logic [CMD_W-1:0] sH_tdata,
    input  logic             mR_tready,
    output logic             mR_tvalid,
    output logic [31:0]      mR_tdata,
    output logic             sR_tready,
    input  logic             sR_tvalid,
    input  logic [31:0]      sR_tdata,
    input  logic             mH_tready,
    output logic             mH_tvalid,
    output logic [31:0]      mH_tdata,
    output logic [7:0]       STRAY
);
    state_e           state_q;
    status_e          status_q;
    logic [CMD_W-1:0] cmd_q;
    logic [15:0]      lat_q;
    logic [7:0]       stray_q;
    logic [15:0]      tmr_cnt;
    logic             tmr_hit;
    logic             key_match;

    jit_cmd_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk_i (ACLK),
        .rst_i (ARESET),
        .clr_i (state_q[I_SEND]),
        .en_i  (state_q[I_WAIT]),
        .cnt_o (tmr_cnt),
        .hit_o (tmr_hit)
    );

    assign key_match = sR_tdata == {28'b0, cmd_key(cmd_q)};

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q  <= IDLE;
            status_q <= ST_ACK;
            cmd_q    <= '0;
            lat_q    <= '0;
            stray_q  <= '0;
        end else begin
            if (sR_tvalid && (state_q[I_IDLE] || state_q[I_RESP]) && stray_q != 8'hFF)
                stray_q <= stray_q + 8'd1;
            case (state_q)
                IDLE: if (sH_tvalid) begin
                    cmd_q   <= sH_tdata;
                    state_q <= SEND;
                end
                SEND: if (mR_tready) state_q <= WAIT;
                // a ring word in the timeout cycle still wins over the timeout
                WAIT: if (sR_tvalid || tmr_hit) begin
                    status_q <= !sR_tvalid ? ST_TIMEOUT : key_match ? ST_ACK : ST_NACK;
                    lat_q    <= tmr_cnt;
                    state_q  <= RESP;
                end
                RESP: if (mH_tready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sH_tready = state_q[I_IDLE];
    assign mR_tvalid = state_q[I_SEND];
    assign sR_tready = !state_q[I_SEND];
    assign mH_tvalid = state_q[I_RESP];
    assign mR_tdata  = {20'b0, cmd_q[KEY_LSB +: FLD_W], cmd_q[CONFB_LSB +: FLD_W],
                        cmd_q[CONFA_LSB +: FLD_W]};
    assign mH_tdata  = {lat_q, 4'b0, cmd_key(cmd_q), 6'b0, status_q};
    assign STRAY     = stray_q;
endmodule

// File: tb/tb_jit_cmd_issuer.sv
// tb_jit_cmd_issuer: directed scoreboard bench for jit_cmd_issuer with a short timeout.
module tb_jit_cmd_issuer;
    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        sH_tready, sH_tvalid = 1'b0;
    logic [11:0] sH_tdata = '0;
    logic        mR_tready = 1'b0, mR_tvalid;
    logic [31:0] mR_tdata;
    logic        sR_tready, sR_tvalid = 1'b0;
    logic [31:0] sR_tdata = '0;
    logic        mH_tready = 1'b0, mH_tvalid;
    logic [31:0] mH_tdata;
    logic [7:0]  STRAY;

    int passed = 0;
    int total = 0;
    logic [31:0] exp_q[$];

    jit_cmd_issuer #(.TIMEOUT_CYCLES(8)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .sH_tready(sH_tready), .sH_tvalid(sH_tvalid), .sH_tdata(sH_tdata),
        .mR_tready(mR_tready), .mR_tvalid(mR_tvalid), .mR_tdata(mR_tdata),
        .sR_tready(sR_tready), .sR_tvalid(sR_tvalid), .sR_tdata(sR_tdata),
        .mH_tready(mH_tready), .mH_tvalid(mH_tvalid), .mH_tdata(mH_tdata),
        .STRAY(STRAY)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] rsp(input logic [1:0] st, input logic [3:0] key,
                                        input logic [15:0] lat);
        return {lat, 4'b0, key, 6'b0, st};
    endfunction

    task automatic tick();
        @(negedge ACLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic txn(input string tag, input logic [11:0] cmd, input int mr_stall,
                       input int ring_at, input logic [31:0] ring_word, input int mh_stall,
                       input int exp_n, input logic [31:0] exp_rsp);
        int n;
        exp_q.push_back(exp_rsp);
        chk({tag, ".sh_rdy"}, 32'(sH_tready), 32'd1);
        sH_tvalid = 1'b1;
        sH_tdata  = cmd;
        tick();
        sH_tvalid = 1'b0;
        sH_tdata  = '0;
        for (int i = 0; i <= mr_stall; i++) begin
            mR_tready = (i == mr_stall);
            chk({tag, ".mr_vld"}, 32'(mR_tvalid), 32'd1);
            chk({tag, ".mr_data"}, mR_tdata, 32'(cmd));
            chk({tag, ".sr_rdy_send"}, 32'(sR_tready), 32'd0);
            chk({tag, ".sh_busy"}, 32'(sH_tready), 32'd0);
            tick();
        end
        mR_tready = 1'b0;
        chk({tag, ".mr_once"}, 32'(mR_tvalid), 32'd0);
        n = 0;
        while (!mH_tvalid && n < 100) begin
            if (n == ring_at) begin
                sR_tvalid = 1'b1;
                sR_tdata  = ring_word;
            end
            tick();
            sR_tvalid = 1'b0;
            sR_tdata  = '0;
            n++;
        end
        chk({tag, ".wait_cycles"}, 32'(n), 32'(exp_n));
        for (int i = 0; i <= mh_stall; i++) begin
            mH_tready = (i == mh_stall);
            chk({tag, ".mh_vld"}, 32'(mH_tvalid), 32'd1);
            chk({tag, ".mh_data"}, mH_tdata, (i == mh_stall) ? exp_q.pop_front() : exp_q[0]);
            tick();
        end
        mH_tready = 1'b0;
        chk({tag, ".mh_once"}, 32'(mH_tvalid), 32'd0);
        chk({tag, ".idle"}, 32'(sH_tready), 32'd1);
        chk({tag, ".stray"}, 32'(STRAY), 32'd0);
    endtask

    initial begin
        tick();
        chk("rst.sh_rdy", 32'(sH_tready), 32'd1);
        chk("rst.mr_vld", 32'(mR_tvalid), 32'd0);
        chk("rst.mr_data", mR_tdata, 32'd0);
        chk("rst.sr_rdy", 32'(sR_tready), 32'd1);
        chk("rst.mh_vld", 32'(mH_tvalid), 32'd0);
        chk("rst.mh_data", mH_tdata, 32'd0);
        chk("rst.stray", 32'(STRAY), 32'd0);
        ARESET = 1'b0;
        tick();

        txn("ack321",   12'h321, 0,  1, 32'h3,         0, 2, rsp(2'b00, 4'h3, 16'd1));
        txn("nack5a7",  12'h5A7, 0,  0, 32'h5A7,       0, 1, rsp(2'b01, 4'h5, 16'd0));
        txn("timeout",  12'h2C1, 0, -1, 32'h0,         0, 8, rsp(2'b10, 4'h2, 16'd7));
        txn("edge_ack", 12'h3FE, 0,  7, 32'h3,         0, 8, rsp(2'b00, 4'h3, 16'd7));
        txn("backpr",   12'h9AB, 5,  2, 32'h9,         3, 3, rsp(2'b00, 4'h9, 16'd2));
        txn("key0ack",  12'h000, 0,  0, 32'h0,         0, 1, rsp(2'b00, 4'h0, 16'd0));
        txn("key0nack", 12'h000, 0,  4, 32'h10,        0, 5, rsp(2'b01, 4'h0, 16'd4));
        txn("hibits",   12'h7C4, 0,  1, 32'h8000_0007, 0, 2, rsp(2'b01, 4'h7, 16'd1));
        chk("sb.empty", 32'(exp_q.size()), 32'd0);

        sR_tvalid = 1'b1;
        sR_tdata  = 32'h3;
        repeat (10) tick();
        chk("stray.10", 32'(STRAY), 32'd10);
        repeat (290) tick();
        chk("stray.sat", 32'(STRAY), 32'd255);
        sR_tvalid = 1'b0;
        tick();
        chk("stray.hold", 32'(STRAY), 32'd255);

        sH_tvalid = 1'b1;
        sH_tdata  = 12'h321;
        tick();
        sH_tvalid = 1'b0;
        mR_tready = 1'b1;
        tick();
        mR_tready = 1'b0;
        chk("arst.in_wait", 32'(sR_tready & ~mR_tvalid & ~sH_tready), 32'd1);
        tick();
        #2 ARESET = 1'b1;
        #1;
        chk("arst.async_idle", 32'(sH_tready), 32'd1);
        chk("arst.async_stray", 32'(STRAY), 32'd0);
        tick();
        ARESET = 1'b0;
        tick();
        sR_tvalid = 1'b1;
        sR_tdata  = 32'h3;
        tick();
        sR_tvalid = 1'b0;
        sR_tdata  = '0;
        chk("arst.late_stray", 32'(STRAY), 32'd1);
        chk("arst.sh_rdy", 32'(sH_tready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("arst.no_rsp", 32'(mH_tvalid), 32'd0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
